pc_redirect_unit: RTL and testbench

- Fetch-side PC owner for the 5-stage pipeline; consumes the EX-stage branch decision (take_branch) and jump/target information.
- Updates the fetch PC and generates IF/ID and ID/EX flushes.
- Buffers a redirect that arrives while an instruction-memory fetch is outstanding.
- Redirects misaligned targets to a trap vector.

---
 rtl/pc_redirect_unit.sv | 114 +++++++++++
 tb/tb_pc_redirect_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: sequential fetch, EX-stage redirects, flush generation,
// deferred redirect while a fetch is in flight. Optional counters: PC_REDIRECT_STATS_EN.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        ex_branch,
  input  logic        take_branch,
  input  logic        ex_jump,
  input  logic [31:0] ex_target,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] taken_count
`endif
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic        r_trap;
  logic [31:0] r_trap_addr;

  logic        w_redirect;
  logic        w_misaligned;
  logic        w_run;
  logic [31:0] w_next_target;

  always_comb begin
    w_redirect    = ex_jump | (ex_branch & take_branch);
    w_misaligned  = (ex_target[1:0] != 2'b00);
    w_next_target = w_misaligned ? TRAP_PC : ex_target;
    w_run         = (r_state == RUN);
  end

  // Redirect/stall inputs are meaningless in WAIT: EX holds a bubble after the flush.
  assign if_valid      = rst_n & w_run & imem_ready & ~w_redirect;
  assign flush_ifid    = rst_n & w_run & w_redirect;
  assign flush_idex    = rst_n & w_run & w_redirect;
  assign pc            = r_pc;
  assign misalign_trap = r_trap;
  assign trap_addr     = r_trap_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pc        <= RESET_PC;
      r_pending   <= '0;
      r_trap      <= 1'b0;
      r_trap_addr <= '0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_redirect) begin
            if (w_misaligned) begin
              r_trap      <= 1'b1;
              r_trap_addr <= ex_target;
            end
            // An in-flight fetch cannot be cancelled, so park the target until it returns.
            if (imem_ready) begin
              r_pc <= w_next_target;
            end else begin
              r_pending <= w_next_target;
              r_state   <= WAIT;
            end
          end else if (imem_ready && !stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            r_pc    <= r_pending;
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_taken_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_count <= '0;
      r_taken_count  <= '0;
    end else if (w_run) begin
      if ((ex_branch || ex_jump) && (r_branch_count != '1))
        r_branch_count <= r_branch_count + 32'd1;
      if (w_redirect && (r_taken_count != '1))
        r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign branch_count = r_branch_count;
  assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit; inputs change 1 time unit
// after the rising edge and outputs are checked there as well.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_ready;
  logic        ex_branch;
  logic        take_branch;
  logic        ex_jump;
  logic [31:0] ex_target;
  logic [31:0] pc;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic        misalign_trap;
  logic [31:0] trap_addr;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] taken_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .TRAP_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .ex_branch    (ex_branch),
    .take_branch  (take_branch),
    .ex_jump      (ex_jump),
    .ex_target    (ex_target),
    .pc           (pc),
    .if_valid     (if_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_trap(misalign_trap),
    .trap_addr    (trap_addr)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .branch_count (branch_count),
    .taken_count  (taken_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    stall = 1'b0; ex_branch = 1'b0; take_branch = 1'b0; ex_jump = 1'b0; ex_target = '0;
  endtask

  task automatic jump(input logic [31:0] t);
    ex_jump = 1'b1; ex_target = t;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; idle_in();
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ifv", {31'b0, if_valid}, 32'd0);
    chk("rst_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'd0);
    chk("rst_trap_addr", trap_addr, 32'h0);

    // Sequential fetch
    rst_n = 1'b1; #1;
    chk("seq_ifv0", {31'b0, if_valid}, 32'd1);
    tick(); chk("seq_pc4", pc, 32'h4);
    chk("seq_ifv4", {31'b0, if_valid}, 32'd1);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pcC", pc, 32'hC);
    tick(); chk("seq_pc10", pc, 32'h10);

    // Taken branch at 0x10
    ex_branch = 1'b1; take_branch = 1'b1; ex_target = 32'h40; #1;
    chk("br_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    chk("br_ifv", {31'b0, if_valid}, 32'd0);
    tick(); idle_in();
    chk("br_pc", pc, 32'h40);

    // Stall, then redirect beats stall
    jump(32'h20); tick(); idle_in();
    chk("j20_pc", pc, 32'h20);
    stall = 1'b1; #1;
    chk("stall_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
    tick(); chk("stall_pc", pc, 32'h20);
    jump(32'h80); #1;
    chk("stallj_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    tick(); idle_in();
    chk("stallj_pc", pc, 32'h80);

    // Redirect during outstanding fetch
    imem_ready = 1'b0; jump(32'h200); #1;
    chk("wait_flush_in", {30'b0, flush_ifid, flush_idex}, 32'd3);
    chk("wait_ifv_in", {31'b0, if_valid}, 32'd0);
    tick(); jump(32'h300);  // must be ignored while waiting
    chk("wait_pc1", pc, 32'h80);
    chk("wait_flush_ign", {30'b0, flush_ifid, flush_idex}, 32'd0);
    tick(); chk("wait_pc2", pc, 32'h80);
    tick(); chk("wait_pc3", pc, 32'h80);
    imem_ready = 1'b1; #1;
    chk("wait_ifv_ret", {31'b0, if_valid}, 32'd0);
    chk("wait_flush_ret", {30'b0, flush_ifid, flush_idex}, 32'd0);
    tick(); idle_in(); #1;
    chk("wait_pc_new", pc, 32'h200);
    chk("wait_run_ifv", {31'b0, if_valid}, 32'd1);

    // Misaligned jump
    jump(32'h102); #1;
    chk("mis_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    tick(); idle_in();
    chk("mis_pc", pc, 32'h100);
    chk("mis_trap", {31'b0, misalign_trap}, 32'd1);
    chk("mis_addr", trap_addr, 32'h102);
    tick();
    chk("mis_trap_off", {31'b0, misalign_trap}, 32'd0);
    chk("mis_pc_next", pc, 32'h104);

    // Wrap at top of address space
    jump(32'hFFFF_FFFC); tick(); idle_in();
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc0", pc, 32'h0);

    // Branch not taken
    ex_branch = 1'b1; take_branch = 1'b0; ex_target = 32'h80; #1;
    chk("nt_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
    chk("nt_ifv", {31'b0, if_valid}, 32'd1);
    tick(); idle_in();
    chk("nt_pc", pc, 32'h4);

    // Misaligned redirect while fetch outstanding
    imem_ready = 1'b0; jump(32'h203); tick(); idle_in();
    chk("misw_pc", pc, 32'h4);
    chk("misw_trap", {31'b0, misalign_trap}, 32'd1);
    chk("misw_addr", trap_addr, 32'h203);
    imem_ready = 1'b1; tick();
    chk("misw_pc_trap", pc, 32'h100);
    chk("misw_trap_off", {31'b0, misalign_trap}, 32'd0);

    // Reset during WAIT drops the pending target
    imem_ready = 1'b0; jump(32'h400); tick(); idle_in();
    chk("rw_pc_hold", pc, 32'h100);
    rst_n = 1'b0; #1;
    chk("rw_ifv", {31'b0, if_valid}, 32'd0);
    tick();
    chk("rw_pc_reset", pc, 32'h0);
    rst_n = 1'b1; imem_ready = 1'b1; #1;
    chk("rw_run_ifv", {31'b0, if_valid}, 32'd1);
    tick(); chk("rw_pc_seq", pc, 32'h4);

`ifdef PC_REDIRECT_STATS_EN
    ex_branch = 1'b1; take_branch = 1'b1; ex_target = 32'h8; tick();
    chk("st_branch1", branch_count, 32'd1);
    chk("st_taken1", taken_count, 32'd1);
    take_branch = 1'b0; tick(); idle_in();
    chk("st_branch2", branch_count, 32'd2);
    chk("st_taken2", taken_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
